// File: rtl/lc3_mem_ctrl_if.sv
// Bundle of channel request/response and memory bus signals for lc3_mem_ctrl.
// master: the controller side. slave: the requesters plus the memory.
interface lc3_mem_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;
  logic [DATA_W-1:0]        rdata;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_complete;
  logic                     busy;

  modport master (
    input  ch_req, ch_we, ch_addr, ch_wdata, mem_rdata, mem_complete,
    output ch_done, ch_err, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
  );

  modport slave (
    output ch_req, ch_we, ch_addr, ch_wdata, mem_rdata, mem_complete,
    input  ch_done, ch_err, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: round-robin arbitration of NUM_CH requesters onto a
// single memory port, with a per-access timeout. IDLE -> ACCESS -> RELEASE.
// All outputs come straight from flops.
module lc3_mem_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic           clock,
  input logic           reset,
  lc3_mem_ctrl_if.master bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic [CH_W-1:0]     pick;
  logic [CH_W-1:0]     idx;
  logic                found;

  // Round-robin pick: first requester above last_grant, wrapping to 0.
  always_comb begin
    pick  = last_grant_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last_grant_q) + i) % NUM_CH);
      if (!found && bus.ch_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    done_d       = '0;
    err_d        = '0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        // A late acknowledge still on the bus blocks a new grant.
        if (found && !bus.mem_complete) begin
          gnt_d   = pick;
          we_d    = bus.ch_we[pick];
          addr_d  = bus.ch_addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d = bus.ch_wdata[int'(pick)*DATA_W +: DATA_W];
          rd_d    = ~bus.ch_we[pick];
          wr_d    = bus.ch_we[pick];
          cnt_d   = CNT_W'(1);  // counts ACCESS cycles, this is the first
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (bus.mem_complete) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          rd_d          = 1'b0;
          wr_d          = 1'b0;
          done_d[gnt_q] = 1'b1;
          last_grant_d  = gnt_q;
          state_d       = RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          err_d[gnt_q] = 1'b1;
          last_grant_d = gnt_q;
          state_d      = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ch_done   = done_q;
  assign bus.ch_err    = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl (NUM_CH=2, TIMEOUT=4): read, write,
// contention, timeout, completion on the timeout cycle, reset mid-access.
module tb_lc3_mem_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  lc3_mem_ctrl_if #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16)) bus ();

  lc3_mem_ctrl #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks everything that a reset must clear.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    32'(bus.mem_rd),    32'h0);
    check({tag, "_wr"},    32'(bus.mem_wr),    32'h0);
    check({tag, "_busy"},  32'(bus.busy),      32'h0);
    check({tag, "_done"},  32'(bus.ch_done),   32'h0);
    check({tag, "_err"},   32'(bus.ch_err),    32'h0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'h0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
    check({tag, "_rdata"}, 32'(bus.rdata),     32'h0);
  endtask

  initial begin
    bus.ch_req       = 2'b00;
    bus.ch_we        = 2'b00;
    bus.ch_addr      = '0;
    bus.ch_wdata     = '0;
    bus.mem_rdata    = '0;
    bus.mem_complete = 1'b0;

    // Reset state
    #2;
    check_reset_outputs("rst");
    tick();
    reset = 1'b0;

    // Single read on ch0: memory answers on the 3rd strobe cycle
    bus.ch_req  = 2'b01;
    bus.ch_addr = {16'h0000, 16'h3000};
    tick();
    check("rd_strobe1", 32'(bus.mem_rd), 32'h1);
    check("rd_nowr",    32'(bus.mem_wr), 32'h0);
    check("rd_addr",    32'(bus.mem_addr), 32'h3000);
    check("rd_busy",    32'(bus.busy), 32'h1);
    tick();
    check("rd_strobe2", 32'(bus.mem_rd), 32'h1);
    tick();
    check("rd_strobe3", 32'(bus.mem_rd), 32'h1);
    bus.mem_complete = 1'b1;
    bus.mem_rdata    = 16'h1234;
    tick();
    check("rd_drop",  32'(bus.mem_rd),  32'h0);
    check("rd_done",  32'(bus.ch_done), 32'h1);
    check("rd_data",  32'(bus.rdata),   32'h1234);
    check("rd_rbusy", 32'(bus.busy),    32'h1);
    bus.mem_complete = 1'b0;
    bus.ch_req       = 2'b00;
    tick();
    check("rd_idle_done", 32'(bus.ch_done), 32'h0);
    check("rd_idle_busy", 32'(bus.busy),    32'h0);

    // Write on ch1: rdata must not change
    bus.ch_req   = 2'b10;
    bus.ch_we    = 2'b10;
    bus.ch_addr  = {16'h4000, 16'h0000};
    bus.ch_wdata = {16'hBEEF, 16'h0000};
    tick();
    check("wr_strobe", 32'(bus.mem_wr),    32'h1);
    check("wr_nord",   32'(bus.mem_rd),    32'h0);
    check("wr_addr",   32'(bus.mem_addr),  32'h4000);
    check("wr_wdata",  32'(bus.mem_wdata), 32'hBEEF);
    tick();
    check("wr_hold",   32'(bus.mem_wr),    32'h1);
    bus.mem_complete = 1'b1;
    bus.mem_rdata    = 16'hDEAD;
    tick();
    check("wr_done",   32'(bus.ch_done), 32'h2);
    check("wr_drop",   32'(bus.mem_wr),  32'h0);
    check("wr_rdata",  32'(bus.rdata),   32'h1234);
    bus.mem_complete = 1'b0;
    bus.ch_req       = 2'b00;
    bus.ch_we        = 2'b00;
    tick();

    // Contention: both held high, order 0,1,0,1 with a 3-cycle cadence
    bus.ch_req  = 2'b11;
    bus.ch_addr = {16'h0200, 16'h0100};
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_rd",   32'(bus.mem_rd),   32'h1);
      check("cont_addr", 32'(bus.mem_addr), (k % 2 == 0) ? 32'h0100 : 32'h0200);
      bus.mem_complete = 1'b1;
      bus.mem_rdata    = 16'(16'hA000 + k);
      tick();
      check("cont_done",  32'(bus.ch_done), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_rdata", 32'(bus.rdata),   32'hA000 + 32'(k));
      bus.mem_complete = 1'b0;
      tick();
      check("cont_idle", 32'(bus.busy), 32'h0);
    end
    bus.ch_req = 2'b00;

    // Timeout: ch0 read, no acknowledge; strobe lasts 4 cycles
    bus.ch_req  = 2'b01;
    bus.ch_addr = {16'h0000, 16'h5000};
    tick();
    check("to_strobe1", 32'(bus.mem_rd), 32'h1);
    tick();
    tick();
    tick();
    check("to_strobe4", 32'(bus.mem_rd), 32'h1);
    check("to_noerr4",  32'(bus.ch_err), 32'h0);
    tick();
    check("to_drop",  32'(bus.mem_rd),  32'h0);
    check("to_err",   32'(bus.ch_err),  32'h1);
    check("to_nodone",32'(bus.ch_done), 32'h0);
    check("to_rdata", 32'(bus.rdata),   32'hA003);
    bus.ch_req = 2'b00;
    tick();
    check("to_idle",   32'(bus.busy),   32'h0);
    check("to_errclr", 32'(bus.ch_err), 32'h0);

    // Completion on the timeout cycle: done only
    bus.ch_req  = 2'b10;
    bus.ch_addr = {16'h6000, 16'h0000};
    tick();
    check("tc_addr", 32'(bus.mem_addr), 32'h6000);
    tick();
    tick();
    tick();
    bus.mem_complete = 1'b1;
    bus.mem_rdata    = 16'hCAFE;
    tick();
    check("tc_done",  32'(bus.ch_done), 32'h2);
    check("tc_noerr", 32'(bus.ch_err),  32'h0);
    check("tc_rdata", 32'(bus.rdata),   32'hCAFE);
    bus.mem_complete = 1'b0;
    bus.ch_req       = 2'b00;
    tick();

    // Reset mid-access: outputs clear without a clock edge
    bus.ch_req  = 2'b11;
    bus.ch_addr = {16'h0200, 16'h0100};
    tick();
    check("mr_rd", 32'(bus.mem_rd), 32'h1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mr_async");
    tick();
    reset = 1'b0;
    // both pending: last_grant is back to 1, so ch0 wins
    tick();
    check("mr_tie_addr", 32'(bus.mem_addr), 32'h0100);
    check("mr_nodone",   32'(bus.ch_done),  32'h0);
    check("mr_noerr",    32'(bus.ch_err),   32'h0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    // only ch1 pending: ch1 granted on the first edge
    bus.ch_req = 2'b10;
    tick();
    check("mr_ch1_addr", 32'(bus.mem_addr), 32'h0200);
    check("mr_ch1_rd",   32'(bus.mem_rd),   32'h1);
    bus.ch_req = 2'b00;
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting channels (ch0 = instruction fetch, ch1 = data); legal range 1..8.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter DATA_W, default 16, memory data width.
REQ-004 Parameter TIMEOUT, default 255, maximum ACCESS cycles before abort; legal range 1..65535.
REQ-005 clock  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ch_req  in  NUM_CH  per-channel access request; held high until that channel's ch_done or ch_err.
REQ-008 ch_we  in  NUM_CH  per-channel write select (1 = write, 0 = read).
REQ-009 ch_addr  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 ch_wdata  in  NUM_CH*DATA_W  packed write data; same packing as ch_addr.
REQ-011 ch_done  out  NUM_CH  one-cycle pulse: access for channel i completed.
REQ-012 ch_err  out  NUM_CH  one-cycle pulse: access for channel i timed out.
REQ-013 rdata  out  DATA_W  read data; valid in the ch_done cycle and held until the next capture.
REQ-014 mem_rd  out  1  memory read strobe.
REQ-015 mem_wr  out  1  memory write strobe.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid while mem_complete is high.
REQ-019 mem_complete  in  1  memory acknowledge for the current strobe.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, ACCESS, RELEASE; all outputs registered.
REQ-022 IDLE: arbitration occurs when any ch_req is high and mem_complete is low; otherwise the FSM stays in IDLE.
REQ-023 Arbitration is round-robin.
  - Grant goes to the first requesting channel after last_grant, searching upward and wrapping past NUM_CH-1 to 0.
  - last_grant resets to NUM_CH-1, so ch0 wins the first tie.
REQ-024 On grant, the controller latches the channel index, address, wdata and we, and moves to ACCESS.
  - mem_rd = ~we or mem_wr = we goes high in the next cycle (1-cycle request-to-strobe latency).
REQ-025 In ACCESS, mem_addr, mem_wdata and the active strobe stay stable; a timeout counter increments each cycle.
REQ-026 ACCESS with mem_complete sampled high:
  - capture mem_rdata into rdata (reads only);
  - deassert the strobe, pulse ch_done[granted], update last_grant;
  - go to RELEASE.
REQ-027 ACCESS with counter = TIMEOUT and mem_complete low:
  - deassert the strobe, pulse ch_err[granted], leave rdata unchanged, update last_grant;
  - go to RELEASE.
REQ-028 If mem_complete arrives in the same cycle the counter reaches TIMEOUT, completion wins: ch_done pulses and ch_err does not.
REQ-029 RELEASE lasts exactly one cycle, then the FSM returns to IDLE; the counter clears.
  - Minimum spacing between accesses is therefore 3 cycles.
REQ-030 A ch_req that drops during ACCESS does not abort the access; the access completes and the done or err pulse is still issued.
REQ-031 A channel whose ch_req is still high after its done or err pulse is treated as a new request and arbitrated normally.
REQ-032 mem_rd and mem_wr are never high together.
  - At most one bit of ch_done|ch_err is high in any cycle.
REQ-033 The timeout counter is wide enough for TIMEOUT and never wraps.

Reset
REQ-034 Asserting reset forces, immediately and regardless of clock:
  - state to IDLE and mem_rd, mem_wr, busy to 0;
  - ch_done, ch_err, mem_addr, mem_wdata, rdata to 0;
  - counter to 0 and last_grant to NUM_CH-1.
REQ-035 Reset during ACCESS abandons the access with no done or err pulse.
  - After release of reset, the first arbitration occurs on the first clock edge with reset low.

Verification
REQ-036 Single read: ch0 req, addr 0x3000, memory completes 2 cycles after mem_rd with data 0x1234 -> mem_rd high for 3 cycles, ch_done[0] pulse, rdata = 0x1234.
REQ-037 Write: ch1 req, we = 1, addr 0x4000, wdata 0xBEEF -> mem_wr high and mem_wdata = 0xBEEF until complete; ch_done[1] pulse; rdata unchanged.
REQ-038 Contention: ch0 and ch1 held high continuously -> grant order 0,1,0,1, with no grant gaps beyond RELEASE + IDLE.
REQ-039 Timeout: TIMEOUT = 4, mem_complete never asserts -> strobe drops after the 4th ACCESS cycle, ch_err pulse, FSM back in IDLE 1 cycle later.
REQ-040 Complete on the timeout cycle -> ch_done only, no ch_err.
REQ-041 Reset asserted mid-ACCESS -> all outputs 0 asynchronously; after reset, pending ch1 is granted before ch0 only if ch0 is not requesting.
